// File: rtl/sher_seq_pkg.sv
// Shared definitions for the SHER operand sequencer.
// Contents: default width parameters, the operand offset scaling shift and
// the sequencer state type.
// Optional feature macro: SHER_SEQ_ALIGN_CHECK_EN adds the ABORT state used
// when a misaligned (odd) frame base is detected.
package sher_seq_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned NUM_SRC_DEF    = 3;
    localparam int unsigned OFF_WIDTH_DEF  = 9;

    // Word offsets become byte offsets (16-bit words).
    localparam int unsigned OFF_SHIFT = 1;

`ifdef SHER_SEQ_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WRITE,
        ST_DONE,
        ST_ABORT
    } seq_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } seq_state_e;
`endif

endpackage

// File: rtl/sher_addr_gen.sv
// Stack-relative address generator.
// Ports:
//   base   - frame base (byte address)
//   off    - unsigned word offset, zero-extended
//   addr_c - combinational byte address base + (off << OFF_SHIFT), wraps
module sher_addr_gen
    import sher_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned OFF_WIDTH  = OFF_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [OFF_WIDTH-1:0]  off,
    output logic [ADDR_WIDTH-1:0] addr_c
);

    // Sum is truncated to ADDR_WIDTH, giving modulo-2^ADDR_WIDTH wrap.
    assign addr_c = base + (ADDR_WIDTH'(off) << OFF_SHIFT);

endmodule

// File: rtl/sher_operand_sequencer.sv
// Multi-cycle operand sequencer: reads NUM_SRC stack-relative operands over
// one handshaked memory port, hands them to the ALU, and conditionally writes
// the ALU result back to a stack-relative destination.
// Ports:
//   CLK, reset                      - clock, synchronous active-high reset
//   start, sp, src_off, dst_off,
//   skip_cmp                        - instruction issue and its fields
//   mem_req/we/addr/wdata/rdata/ready - single-ported memory handshake
//   operands                        - captured source operands
//   alu_result, alu_cmp             - ALU response, sampled in EXEC
//   busy, done, fault               - status
// Optional feature macro: SHER_SEQ_ALIGN_CHECK_EN aborts an instruction with
// an odd frame base (fault pulse); otherwise fault is tied low.
module sher_operand_sequencer
    import sher_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter int unsigned OFF_WIDTH  = OFF_WIDTH_DEF
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         sp,
    input  logic [NUM_SRC*OFF_WIDTH-1:0]  src_off,
    input  logic [OFF_WIDTH-1:0]          dst_off,
    input  logic                          skip_cmp,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_ready,
    output logic [NUM_SRC*DATA_WIDTH-1:0] operands,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_cmp,
    output logic                          busy,
    output logic                          done,
    output logic                          fault
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    seq_state_e                   state;
    logic [IDX_W-1:0]             idx;
    logic [ADDR_WIDTH-1:0]        sp_q;
    logic [NUM_SRC*OFF_WIDTH-1:0] src_q;
    logic [OFF_WIDTH-1:0]         dst_q;
    logic                         skip_q;

    logic [ADDR_WIDTH-1:0]        gen_base;
    logic [OFF_WIDTH-1:0]         gen_off;
    logic [ADDR_WIDTH-1:0]        gen_addr;
    logic                         xfer;

    assign xfer = mem_req & mem_ready;

    // Address of the *next* request; mem_addr is registered from this so it
    // is valid in the first cycle of each request. In IDLE the live inputs
    // are used because the captured fields are not yet loaded.
    always_comb begin
        gen_base = sp_q;
        gen_off  = dst_q;
        if (state == ST_IDLE) begin
            gen_base = sp;
            gen_off  = src_off[0 +: OFF_WIDTH];
        end else if (state == ST_FETCH) begin
            for (int i = 0; i < int'(NUM_SRC) - 1; i++) begin
                if (idx == IDX_W'(i)) begin
                    gen_off = src_q[(i + 1) * OFF_WIDTH +: OFF_WIDTH];
                end
            end
        end
    end

    sher_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OFF_WIDTH  (OFF_WIDTH)
    ) u_addr_gen (
        .base   (gen_base),
        .off    (gen_off),
        .addr_c (gen_addr)
    );

    // Sequencer FSM with registered memory and status outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            sp_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            skip_q    <= 1'b0;
            operands  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SHER_SEQ_ALIGN_CHECK_EN
            fault     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SHER_SEQ_ALIGN_CHECK_EN
            fault <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sp_q   <= sp;
                        src_q  <= src_off;
                        dst_q  <= dst_off;
                        skip_q <= skip_cmp;
                        idx    <= '0;
                        busy   <= 1'b1;
`ifdef SHER_SEQ_ALIGN_CHECK_EN
                        // Offsets are word-scaled, so only an odd sp can
                        // make any address of this instruction odd.
                        if (gen_addr[0]) begin
                            state <= ST_ABORT;
                            fault <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= gen_addr;
                        end
`else
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= gen_addr;
`endif
                    end
                end

                ST_FETCH: begin
                    if (xfer) begin
                        for (int i = 0; i < int'(NUM_SRC); i++) begin
                            if (idx == IDX_W'(i)) begin
                                operands[i * DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state   <= ST_EXEC;
                            mem_req <= 1'b0;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            mem_addr <= gen_addr;
                        end
                    end
                end

                ST_EXEC: begin
                    mem_wdata <= alu_result;
                    if (skip_q | alu_cmp) begin
                        state    <= ST_WRITE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= gen_addr;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (xfer) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

`ifdef SHER_SEQ_ALIGN_CHECK_EN
                ST_ABORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
`endif

                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef SHER_SEQ_ALIGN_CHECK_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_sher_operand_sequencer.sv
// Scoreboard bench for sher_operand_sequencer: the driver pushes the expected
// memory requests and completion for each instruction; a negedge monitor
// checks every presented request and every done pulse against them.
module tb_sher_operand_sequencer;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned OW = 9;

    logic               CLK;
    logic               reset;
    logic               start;
    logic [AW-1:0]      sp;
    logic [NS*OW-1:0]   src_off;
    logic [OW-1:0]      dst_off;
    logic               skip_cmp;
    logic               mem_req;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_ready;
    logic [NS*DW-1:0]   operands;
    logic [DW-1:0]      alu_result;
    logic               alu_cmp;
    logic               busy;
    logic               done;
    logic               fault;

    sher_operand_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_SRC    (NS),
        .OFF_WIDTH  (OW)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .sp         (sp),
        .src_off    (src_off),
        .dst_off    (dst_off),
        .skip_cmp   (skip_cmp),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .operands   (operands),
        .alu_result (alu_result),
        .alu_cmp    (alu_cmp),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    typedef struct {
        logic [NS*DW-1:0] ops;
        int               base_lat;
    } done_t;

    xfer_t exp_xfer[$];
    done_t exp_done[$];

    int errors = 0;
    int checks = 0;

    // Responder control: 0 random ready, 1 always ready, 3 stall all writes,
    // 4 stall reads of stall_addr for stall_budget cycles.
    int            ready_mode = 1;
    logic [AW-1:0] stall_addr = '0;
    int            stall_budget = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Memory contents model: a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return DW'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    assign mem_rdata = mem_val(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory ready responder, updated just after each rising edge.
    always @(posedge CLK) begin : responder
        int stall_used;
        #1;
        if (ready_mode != 4) stall_used = 0;
        case (ready_mode)
            0: mem_ready = ($urandom_range(0, 3) != 0);
            3: mem_ready = !mem_we;
            4: begin
                if (mem_req && !mem_we && mem_addr == stall_addr && stall_used < stall_budget) begin
                    mem_ready = 1'b0;
                    stall_used++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b1;
        endcase
    end

    initial mem_ready = 1'b1;

    // Monitor: compares every request/done against the scoreboard.
    always @(negedge CLK) begin : monitor
        int    cyc;
        int    t0;
        int    stalls;
        bit    in_flight;
        bit    busy_low_chk;
        xfer_t h;
        done_t d;
        cyc++;
        if (reset) begin
            exp_xfer.delete();
            exp_done.delete();
            in_flight    = 0;
            busy_low_chk = 0;
        end else begin
            if (busy_low_chk) begin
                chk("busy_fall", 64'(busy), 64'd0);
                busy_low_chk = 0;
            end
            if (start && !busy && exp_done.size() > 0) begin
                t0        = cyc;
                stalls    = 0;
                in_flight = 1;
            end else if (in_flight) begin
                chk("busy_high", 64'(busy), 64'd1);
            end
`ifndef SHER_SEQ_ALIGN_CHECK_EN
            if (fault) chk("fault_tied_low", 64'(fault), 64'd0);
`endif
            if (mem_req) begin
                if (exp_xfer.size() == 0) begin
                    chk("unexpected_req", 64'(mem_req), 64'd0);
                end else begin
                    h = exp_xfer[0];
                    chk("req_addr", 64'(mem_addr), 64'(h.addr));
                    chk("req_we", 64'(mem_we), 64'(h.we));
                    if (h.we) chk("req_wdata", 64'(mem_wdata), 64'(h.data));
                    if (mem_ready) void'(exp_xfer.pop_front());
                    else stalls++;
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_operands", 64'(operands), 64'(d.ops));
                    chk("done_latency", 64'(cyc - t0), 64'(d.base_lat + stalls));
                    chk("done_pending_xfers", 64'(exp_xfer.size()), 64'd0);
                    in_flight    = 0;
                    busy_low_chk = 1;
                end
            end
        end
    end

    function automatic logic [NS*OW-1:0] pack3(input int o0, input int o1, input int o2);
        return {OW'(o2), OW'(o1), OW'(o0)};
    endfunction

    // Issue one instruction (called just after a rising edge with DUT idle).
    task automatic issue(input logic [AW-1:0] s, input logic [NS*OW-1:0] offs,
                         input logic [OW-1:0] d, input logic sk, input logic cmp,
                         input logic [DW-1:0] res);
        logic [NS*DW-1:0] ops;
        logic [AW-1:0]    a;
        logic [OW-1:0]    o;
        xfer_t            x;
        done_t            dn;
        logic             wb;
        ops = '0;
        for (int i = 0; i < int'(NS); i++) begin
            o = offs[i*OW +: OW];
            a = s + AW'(32'(o) * 2);
            x.we = 1'b0; x.addr = a; x.data = '0;
            exp_xfer.push_back(x);
            ops[i*DW +: DW] = mem_val(a);
        end
        wb = sk | cmp;
        if (wb) begin
            x.we = 1'b1; x.addr = s + AW'(32'(d) * 2); x.data = res;
            exp_xfer.push_back(x);
        end
        dn.ops = ops;
        dn.base_lat = int'(NS) + 2 + (wb ? 1 : 0);
        exp_done.push_back(dn);
        sp = s; src_off = offs; dst_off = d; skip_cmp = sk;
        alu_cmp = cmp; alu_result = res;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout actual=no_done expected=done");
        end
        @(posedge CLK); #1;
    endtask

    initial begin : driver
        logic [AW-1:0]    s;
        logic [NS*OW-1:0] offs;
        int               n;
        reset = 1'b1; start = 1'b0; sp = '0; src_off = '0; dst_off = '0;
        skip_cmp = 1'b0; alu_result = '0; alu_cmp = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_operands", 64'(operands), 64'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        // Write-back via compare flag; back-to-back no-write instruction.
        issue(16'h0100, pack3(1, 2, 3), 9'd4, 1'b0, 1'b1, 16'hBEEF);
        wait_done();
        issue(16'h0100, pack3(1, 2, 3), 9'd4, 1'b0, 1'b0, 16'h1234);
        wait_done();
        chk("operands_hold", 64'(operands),
            64'({mem_val(16'h0106), mem_val(16'h0104), mem_val(16'h0102)}));

        // Two-cycle stall on operand 1.
        ready_mode = 4; stall_addr = 16'h0104; stall_budget = 2;
        issue(16'h0100, pack3(1, 2, 3), 9'd4, 1'b1, 1'b0, 16'h0F0F);
        wait_done();
        ready_mode = 1;

        // Address wrap.
        issue(16'hFFFE, pack3(2, 0, 511), 9'd2, 1'b1, 1'b0, 16'hA5A5);
        wait_done();

        // Reset during a stalled write, with a coincident start.
        ready_mode = 3;
        issue(16'h0200, pack3(5, 6, 7), 9'd8, 1'b1, 1'b0, 16'hCAFE);
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("reach_write", 64'(mem_req && mem_we), 64'd1);
        @(posedge CLK); #1;
        reset = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0; start = 1'b0;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(posedge CLK); #1;
        chk("rst_start_dropped", 64'(busy), 64'd0);
        ready_mode = 1;
        @(posedge CLK); #1;
        issue(16'h0300, pack3(0, 1, 2), 9'd3, 1'b0, 1'b1, 16'h7777);
        wait_done();

`ifdef SHER_SEQ_ALIGN_CHECK_EN
        // Odd frame base aborts before any request.
        sp = 16'h0101; src_off = pack3(1, 2, 3); dst_off = 9'd4; skip_cmp = 1'b1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("abort_fault", 64'(fault), 64'd1);
        chk("abort_no_req", 64'(mem_req), 64'd0);
        @(posedge CLK); #1;
        chk("abort_fault_pulse", 64'(fault), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(done), 64'd0);
`endif

        // Randomized instructions with random memory readiness.
        for (int k = 0; k < 40; k++) begin
            ready_mode = 0;
            s = AW'($urandom);
`ifdef SHER_SEQ_ALIGN_CHECK_EN
            s[0] = 1'b0;
`endif
            offs = (NS*OW)'($urandom);
            issue(s, offs, OW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom));
            wait_done();
            n = int'($urandom_range(0, 2));
            repeat (n) begin
                @(posedge CLK); #1;
            end
        end
        ready_mode = 1;

        repeat (5) @(posedge CLK);
        #1;
        chk("final_xfer_queue", 64'(exp_xfer.size()), 64'd0);
        chk("final_done_queue", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
